// File: rtl/mux2_1_if.sv
// mux2_1_if: request/response handshake bundle for the registered 2:1 mux
interface mux2_1_if #(parameter int WIDTH = 64) ();
  logic               sel;
  logic [2*WIDTH-1:0] in;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   out;
  logic               out_valid;
  logic               out_ready;
  modport master (output sel, in, in_valid, out_ready, input in_ready, out, out_valid);
  modport slave  (input sel, in, in_valid, out_ready, output in_ready, out, out_valid);
endinterface

// File: rtl/mux2_1.sv
// mux2_1: registered 2:1 operand select behind a two-entry skid buffer
module mux2_1 #(parameter int WIDTH = 64) (
  input logic     clk,
  input logic     reset,
  mux2_1_if.slave bus
);
  logic [WIDTH-1:0] out_q, out_d, skid_q, skid_d, result;
  logic             out_v_q, out_v_d, skid_v_q, skid_v_d;
  logic             out_fire, in_fire, load, in_ready;
  assign in_ready      = ~skid_v_q & ~reset;
  assign bus.in_ready  = in_ready;
  assign bus.out       = out_q;
  assign bus.out_valid = out_v_q;
  always_comb begin
    out_fire = out_v_q & bus.out_ready;
    in_fire  = bus.in_valid & in_ready;
    result   = bus.sel ? bus.in[2*WIDTH-1:WIDTH] : bus.in[WIDTH-1:0];
    // output register is free when empty or draining; skid entry always has priority
    load     = ~out_v_q | out_fire;
    out_d    = load ? (skid_v_q ? skid_q : (in_fire ? result : out_q)) : out_q;
    out_v_d  = load ? (skid_v_q | in_fire) : 1'b1;
    skid_d   = (~load & in_fire) ? result : skid_q;
    skid_v_d = load ? 1'b0 : (skid_v_q | in_fire);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q    <= '0;
      out_v_q  <= 1'b0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      out_v_q  <= out_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
    end
  end
endmodule

// File: tb/tb_mux2_1.sv
// tb_mux2_1: vector table, directed handshake sequences and a queue-model random run
module tb_mux2_1;
  localparam int W = 64;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  mux2_1_if #(.WIDTH(W)) b ();
  mux2_1 #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(b));
  always #5 clk = ~clk;
  typedef struct {
    logic         sel;
    logic [W-1:0] op1;
    logic [W-1:0] op0;
    logic [W-1:0] exp;
  } vec_t;
  vec_t vecs[6];
  logic [W-1:0] q[$];
  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic drive(logic v, logic s, logic [W-1:0] o1, logic [W-1:0] o0, logic rdy);
    b.in_valid  = v;
    b.sel       = s;
    b.in        = {o1, o0};
    b.out_ready = rdy;
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic drain();
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    tick();
    tick();
    tick();
  endtask
  initial begin
    vecs[0] = '{1'b0, 64'hfff, 64'hccc, 64'hccc};
    vecs[1] = '{1'b1, 64'hfff, 64'hccc, 64'hfff};
    vecs[2] = '{1'b0, 64'hffff_ffff_ffff_ffff, 64'h0, 64'h0};
    vecs[3] = '{1'b1, 64'hffff_ffff_ffff_ffff, 64'h0, 64'hffff_ffff_ffff_ffff};
    vecs[4] = '{1'b1, 64'h8000_0000_0000_0001, 64'h7fff_ffff_ffff_fffe, 64'h8000_0000_0000_0001};
    vecs[5] = '{1'b0, 64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210, 64'hfedc_ba98_7654_3210};
    reset = 1'b1;
    drive(1'b1, 1'b1, 64'h55, 64'haa, 1'b1);
    tick();
    tick();
    chk("reset_out_valid", {63'd0, b.out_valid}, 64'd0);
    chk("reset_out", b.out, 64'd0);
    chk("reset_in_ready", {63'd0, b.in_ready}, 64'd0);
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    #1 chk("post_reset_in_ready", {63'd0, b.in_ready}, 64'd1);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].sel, vecs[i].op1, vecs[i].op0, 1'b1);
      tick();
      b.in_valid = 1'b0;
      chk($sformatf("vec%0d_out", i), b.out, vecs[i].exp);
      chk($sformatf("vec%0d_valid", i), {63'd0, b.out_valid}, 64'd1);
      tick();
    end
    drain();
    // streaming: alternate sel, one result per cycle
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i[0], 64'h100 + 64'(i), 64'h200 + 64'(i), 1'b1);
      #1 chk($sformatf("stream_in_ready%0d", i), {63'd0, b.in_ready}, 64'd1);
      tick();
      chk($sformatf("stream_out%0d", i), b.out, i[0] ? 64'h100 + 64'(i) : 64'h200 + 64'(i));
      chk($sformatf("stream_valid%0d", i), {63'd0, b.out_valid}, 64'd1);
    end
    drain();
    // backpressure: second request lands in the skid register
    drive(1'b1, 1'b0, 64'h1, 64'hA, 1'b0);
    tick();
    chk("bp_first_out", b.out, 64'hA);
    chk("bp_in_ready_1", {63'd0, b.in_ready}, 64'd1);
    drive(1'b1, 1'b1, 64'hB, 64'h2, 1'b0);
    tick();
    b.in_valid = 1'b0;
    chk("bp_in_ready_full", {63'd0, b.in_ready}, 64'd0);
    chk("bp_hold_out", b.out, 64'hA);
    tick();
    chk("bp_hold_out2", b.out, 64'hA);
    chk("bp_hold_valid", {63'd0, b.out_valid}, 64'd1);
    b.out_ready = 1'b1;
    tick();
    chk("bp_second_out", b.out, 64'hB);
    chk("bp_in_ready_back", {63'd0, b.in_ready}, 64'd1);
    tick();
    chk("bp_drained", {63'd0, b.out_valid}, 64'd0);
    // reset with both registers full
    drive(1'b1, 1'b0, 64'h0, 64'hC1, 1'b0);
    tick();
    drive(1'b1, 1'b0, 64'h0, 64'hC2, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    chk("rst_mid_valid", {63'd0, b.out_valid}, 64'd0);
    chk("rst_mid_out", b.out, 64'd0);
    chk("rst_mid_in_ready", {63'd0, b.in_ready}, 64'd0);
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    #1 chk("rst_mid_in_ready_after", {63'd0, b.in_ready}, 64'd1);
    tick();
    chk("rst_mid_no_stale", {63'd0, b.out_valid}, 64'd0);
    tick();
    chk("rst_mid_no_stale2", {63'd0, b.out_valid}, 64'd0);
    // isolation: input wiggles without a transfer must not reach out
    drive(1'b1, 1'b1, 64'hD0D0, 64'h0E0E, 1'b0);
    tick();
    b.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b.sel = i[0];
      b.in  = {64'($urandom), 64'($urandom)};
      tick();
      chk($sformatf("iso_out%0d", i), b.out, 64'hD0D0);
      chk($sformatf("iso_valid%0d", i), {63'd0, b.out_valid}, 64'd1);
    end
    drain();
    // random traffic against a FIFO model of capacity two
    q.delete();
    for (int n = 0; n < 400; n++) begin
      logic         v, s, rdy, push, pop;
      logic [W-1:0] o1, o0;
      chk("rnd_valid", {63'd0, b.out_valid}, {63'd0, q.size() > 0});
      if (q.size() > 0) chk("rnd_out", b.out, q[0]);
      reset = ($urandom % 50) == 0;
      v   = 1'($urandom);
      s   = 1'($urandom);
      rdy = ($urandom % 4) != 0;
      o1  = {32'($urandom), 32'($urandom)};
      o0  = {32'($urandom), 32'($urandom)};
      drive(v, s, o1, o0, rdy);
      #1 chk("rnd_in_ready", {63'd0, b.in_ready}, {63'd0, !reset && q.size() < 2});
      if (reset) q.delete();
      else begin
        pop  = q.size() > 0 && rdy;
        push = v && q.size() < 2;
        if (pop) void'(q.pop_front());
        if (push) q.push_back(s ? o1 : o0);
      end
      tick();
    end
    reset = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
